// File: rtl/fsm_unreach_param.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | fsm_unreach_param: parametrised FSM-extraction and recovery test block  |
// | with start handshake, timed hold, done pulse and busy flag.             |
// | Optional macro FSM_STATE_OUT_EN adds the state_o debug port.            |
// | Revision: 1.0                                                           |
// +------------------------------------------------------------------------+
module fsm_unreach_param #(
    parameter int W      = 5,
    parameter int HOLD   = 4,
    parameter int THRESH = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [W-1:0] c,
    output logic [W-1:0] x,
    output logic [W-1:0] y,
    output logic [W-1:0] z,
    output logic         busy,
`ifdef FSM_STATE_OUT_EN
    output logic [3:0]   state_o,
`endif
    output logic         done
);

    typedef enum logic [3:0] {
        S_IDLE = 4'd1,
        S_EVAL = 4'd2,
        S_SWAP = 4'd3,
        S_HOLD = 4'd4,
        S_SP5  = 4'd5,
        S_SP6  = 4'd6
    } state_t;

    localparam int           CW      = $clog2(HOLD + 1);
    localparam logic [CW-1:0] C_HOLD_LD = CW'(HOLD - 1);
    localparam logic [W-1:0]  C_THR     = W'(THRESH);

    state_t        state_q, state_d;
    logic [W-1:0]  x_q, x_d;
    logic [W-1:0]  y_q, y_d;
    logic [W-1:0]  z_q, z_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          done_q, done_d;

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        z_d     = z_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                y_d = b;
                z_d = W'(1);
                if (start) begin
                    state_d = S_EVAL;
                end
            end
            S_EVAL: begin
                x_d = a;
                y_d = c;
                z_d = c;
                // The y compare has priority over the x compare.
                if (y_q < C_THR) begin
                    state_d = S_SWAP;
                end else if (x_q < C_THR) begin
                    state_d = S_HOLD;
                    cnt_d   = C_HOLD_LD;
                end
            end
            S_SWAP: begin
                x_d     = y_q;
                y_d     = a;
                z_d     = y_q;
                state_d = S_IDLE;
                done_d  = 1'b1;
            end
            S_HOLD: begin
                x_d = b;
                y_d = W'(1);
                z_d = W'(2);
                if (cnt_q == '0) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: begin
                // Spare and illegal encodings fall back to IDLE without a done pulse.
                x_d     = W'(1);
                y_d     = W'(2);
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            x_q     <= W'(1);
            y_q     <= W'(2);
            z_q     <= W'(3);
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            z_q     <= z_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    assign x    = x_q;
    assign y    = y_q;
    assign z    = z_q;
    assign done = done_q;
    assign busy = (state_q != S_IDLE);
`ifdef FSM_STATE_OUT_EN
    assign state_o = state_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fsm_unreach_param.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | tb_fsm_unreach_param: directed vectors with a queued expected-response  |
// | scoreboard for fsm_unreach_param (W=5, HOLD=4, THRESH=3).               |
// | Revision: 1.0                                                           |
// +------------------------------------------------------------------------+
module tb_fsm_unreach_param;

    localparam int W = 5;

    logic         clk   = 1'b0;
    logic         rst   = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] a     = '0;
    logic [W-1:0] b     = '0;
    logic [W-1:0] c     = '0;
    logic [W-1:0] x, y, z;
    logic         busy, done;
`ifdef FSM_STATE_OUT_EN
    logic [3:0]   state_o;
`endif

    fsm_unreach_param #(.W(W), .HOLD(4), .THRESH(3)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .a      (a),
        .b      (b),
        .c      (c),
        .x      (x),
        .y      (y),
        .z      (z),
        .busy   (busy),
`ifdef FSM_STATE_OUT_EN
        .state_o(state_o),
`endif
        .done   (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int id;
        int ex;
        int ey;
        int ez;
        int est;
        int edn;
    } exp_t;

    exp_t q[$];
    int   n_vec  = 0;
    int   n_bad  = 0;
    int   vec_id = 0;
    logic smp_tgl = 1'b0;

    task automatic chk(input string name, input int id, input int act, input int req);
        n_vec++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s (vector %0d): got %0d, expected %0d", name, id, act, req);
        end
    endtask

    // Monitor: samples 1 time unit after each rising edge, or after an
    // asynchronous sample request, and pops one expectation if present.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk or smp_tgl);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("x",    e.id, int'(x),    e.ex);
                chk("y",    e.id, int'(y),    e.ey);
                chk("z",    e.id, int'(z),    e.ez);
                chk("busy", e.id, int'(busy), (e.est != 1) ? 1 : 0);
                chk("done", e.id, int'(done), e.edn);
`ifdef FSM_STATE_OUT_EN
                chk("state_o", e.id, int'(state_o), e.est);
`endif
            end
        end
    end

    function automatic exp_t mk(input int ex, ey, ez, est, edn);
        exp_t e;
        vec_id++;
        e.id  = vec_id;
        e.ex  = ex;
        e.ey  = ey;
        e.ez  = ez;
        e.est = est;
        e.edn = edn;
        return e;
    endfunction

    // Drive inputs on the falling edge; expectation applies after the next rising edge.
    task automatic step(input logic r, input logic s, input int ia, ib, ic,
                        input int ex, ey, ez, est, edn);
        @(negedge clk);
        rst   = r;
        start = s;
        a     = W'(ia);
        b     = W'(ib);
        c     = W'(ic);
        q.push_back(mk(ex, ey, ez, est, edn));
    endtask

    task automatic async_reset_check();
        rst = 1'b0;
        q.push_back(mk(1, 2, 3, 1, 0));
        smp_tgl = ~smp_tgl;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        #1;
        async_reset_check();
        #4;

        // Idle tracking
        repeat (3) step(1, 0, 0, 7, 0,   1, 7, 1, 1, 0);

        // HOLD path from x=1
        step(1, 1, 0, 8, 0,   1, 8, 1, 2, 0);
        step(1, 0, 0, 6, 0,   0, 0, 0, 4, 0);
        repeat (3) step(1, 0, 0, 6, 0,   6, 1, 2, 4, 0);
        step(1, 0, 0, 6, 0,   6, 1, 2, 1, 1);
        step(1, 0, 0, 6, 0,   6, 6, 1, 1, 0);

        // SWAP path
        step(1, 1, 0, 2, 0,   6, 2, 1, 2, 0);
        step(1, 0, 9, 2, 10,  9, 10, 10, 3, 0);
        step(1, 0, 4, 2, 10,  10, 4, 10, 1, 1);
        step(1, 0, 0, 5, 0,   10, 5, 1, 1, 0);

        // Priority: both compares true goes to SWAP
        step(1, 1, 0, 5, 0,   10, 5, 1, 2, 0);
        step(1, 0, 0, 5, 0,   0, 0, 0, 2, 0);
        step(1, 0, 5, 5, 5,   5, 5, 5, 3, 0);
        step(1, 0, 7, 5, 5,   5, 7, 5, 1, 1);

        // Stall in EVAL with x=y=5
        step(1, 1, 5, 5, 5,   5, 5, 1, 2, 0);
        repeat (4) step(1, 0, 5, 5, 5,   5, 5, 5, 2, 0);

        // Into HOLD, then asynchronous reset mid-cycle
        step(1, 0, 1, 5, 5,   1, 5, 5, 2, 0);
        step(1, 0, 1, 6, 5,   1, 5, 5, 4, 0);
        step(1, 0, 1, 6, 5,   6, 1, 2, 4, 0);
        @(negedge clk);
        #2;
        async_reset_check();
        step(0, 0, 0, 3, 0,   1, 2, 3, 1, 0);
        repeat (5) step(1, 0, 0, 3, 0,   1, 3, 1, 1, 0);

        // Back-to-back with start held high
        step(1, 1, 0, 2, 1,   1, 2, 1, 2, 0);
        step(1, 1, 0, 2, 1,   0, 1, 1, 3, 0);
        step(1, 1, 0, 2, 1,   1, 0, 1, 1, 1);
        step(1, 1, 0, 2, 1,   1, 2, 1, 2, 0);
        step(1, 1, 0, 2, 1,   0, 1, 1, 3, 0);
        step(1, 0, 0, 2, 1,   1, 0, 1, 1, 1);
        step(1, 0, 0, 2, 1,   1, 2, 1, 1, 0);

        @(posedge clk);
        #3;
        chk("queue_drained", vec_id, q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
